// File: rtl/csr_timer_pkg.sv
// csr_timer_pkg
//   Shared constants for the CSR timer bank: CSR offsets relative to the bank
//   base, the per-channel stride, TCFG field bit positions and the masked-write
//   helper used by every writable register in the bank.
package csr_timer_pkg;

    // CSR offsets. TID is at the base; channel registers sit at base + 8*i + ofs.
    localparam logic [13:0] TID_OFS     = 14'd0;
    localparam logic [13:0] TCFG_OFS    = 14'd1;
    localparam logic [13:0] TVAL_OFS    = 14'd2;
    localparam logic [13:0] TICLR_OFS   = 14'd4;
    localparam int          CHAN_STRIDE = 8;

    // TCFG field layout: {initval, periodic, en}.
    localparam int TCFG_EN         = 0;
    localparam int TCFG_PERIOD     = 1;
    localparam int TCFG_INITVAL_LO = 2;

    // Bits selected by mask take the new value; the rest keep the old one.
    function automatic logic [31:0] masked_write(input logic [31:0] old_value,
                                                 input logic [31:0] mask,
                                                 input logic [31:0] value);
        return (mask & value) | (~mask & old_value);
    endfunction

endpackage

// File: rtl/csr_timer_chan.sv
// csr_timer_chan
//   One countdown timer channel: TCFG fields, the down counter and the
//   pending-interrupt flag.
// Ports
//   clk, reset   clock, asynchronous active-high reset
//   halt         freeze the counter and suppress interrupt setting
//   cfg_we       TCFG write strobe (already decoded)
//   ticlr_we     TICLR write strobe (already decoded)
//   wr_mask      CSR write mask
//   wr_value     CSR write data
//   cfg          current TCFG contents {initval, periodic, en}
//   cnt          current counter value (TVAL)
//   pending      registered timer interrupt
module csr_timer_chan
    import csr_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             halt,
    input  logic             cfg_we,
    input  logic             ticlr_we,
    input  logic [31:0]      wr_mask,
    input  logic [31:0]      wr_value,
    output logic [CNT_W-1:0] cfg,
    output logic [CNT_W-1:0] cnt,
    output logic             pending
);

    logic [CNT_W-1:0] cfg_next;
    logic [CNT_W-1:0] reload;
    logic [CNT_W-1:0] next_reload;
    logic             en;
    logic             periodic;
    logic             cnt_ones;
    logic             cnt_zero;
    logic             clr_req;

    assign cfg_next    = CNT_W'(masked_write(32'(cfg), wr_mask, wr_value));
    assign en          = cfg[TCFG_EN];
    assign periodic    = cfg[TCFG_PERIOD];
    assign reload      = {cfg[CNT_W-1:TCFG_INITVAL_LO], 2'b00};
    assign next_reload = {cfg_next[CNT_W-1:TCFG_INITVAL_LO], 2'b00};
    // All-ones is the "stopped" marker a one-shot timer parks at after zero.
    assign cnt_ones    = &cnt;
    assign cnt_zero    = (cnt == '0);
    assign clr_req     = ticlr_we && wr_mask[0] && wr_value[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg     <= '0;
            cnt     <= '1;
            pending <= 1'b0;
        end else begin
            if (cfg_we) begin
                cfg <= cfg_next;
            end

            // A TCFG write that leaves en=0 must hold the counter even though
            // the old en may still be 1, hence cfg_we sits in the hold branch.
            if (cfg_we && cfg_next[TCFG_EN]) begin
                cnt <= next_reload;
            end else if (cfg_we || halt) begin
                cnt <= cnt;
            end else if (en && !cnt_ones) begin
                cnt <= (cnt_zero && periodic) ? reload : cnt - CNT_W'(1);
            end

            // Setting takes precedence over a simultaneous TICLR clear.
            if (en && cnt_zero && !halt) begin
                pending <= 1'b1;
            end else if (clr_req) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/csr_timer_bank.sv
// csr_timer_bank
//   Multi-channel constant-timer unit on the CSR bus: NUM_TIMERS countdown
//   channels, a free-running stable counter and the TID register. Read data is
//   combinational and meant to be ORed with the main CSR file's read data.
// Ports
//   clk, reset      clock, asynchronous active-high reset
//   halt            debug freeze for the timers (stable counter keeps going)
//   csr_we/wr_num/wr_mask/wr_value   masked CSR write port
//   csr_re/rd_num   CSR read port
//   csr_rd_value    read data, 0 when not reading or number unmapped
//   stable_cnt      free-running counter
//   timer_int       per-channel pending interrupt
//   has_timer_int   OR of timer_int
module csr_timer_bank
    import csr_timer_pkg::*;
#(
    parameter int          NUM_TIMERS = 2,
    parameter int          CNT_W      = 32,
    parameter int          STABLE_W   = 64,
    parameter logic [13:0] CSR_BASE   = 14'h40,
    parameter logic [31:0] CORE_ID    = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  halt,
    input  logic                  csr_we,
    input  logic [13:0]           csr_wr_num,
    input  logic [31:0]           csr_wr_mask,
    input  logic [31:0]           csr_wr_value,
    input  logic                  csr_re,
    input  logic [13:0]           csr_rd_num,
    output logic [31:0]           csr_rd_value,
    output logic [STABLE_W-1:0]   stable_cnt,
    output logic [NUM_TIMERS-1:0] timer_int,
    output logic                  has_timer_int
);

    logic [31:0] tid;
    logic [31:0] chan_rd [NUM_TIMERS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tid        <= CORE_ID;
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + STABLE_W'(1);
            if (csr_we && csr_wr_num == CSR_BASE + TID_OFS) begin
                tid <= masked_write(tid, csr_wr_mask, csr_wr_value);
            end
        end
    end

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_chan
        localparam logic [13:0] CH_BASE = CSR_BASE + 14'(CHAN_STRIDE * i);

        logic [CNT_W-1:0] cfg;
        logic [CNT_W-1:0] cnt;
        logic             pending;
        logic             cfg_we;
        logic             ticlr_we;
        logic             rd_cfg;
        logic             rd_val;

        assign cfg_we   = csr_we && (csr_wr_num == CH_BASE + TCFG_OFS);
        assign ticlr_we = csr_we && (csr_wr_num == CH_BASE + TICLR_OFS);
        assign rd_cfg   = (csr_rd_num == CH_BASE + TCFG_OFS);
        assign rd_val   = (csr_rd_num == CH_BASE + TVAL_OFS);

        csr_timer_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .halt     (halt),
            .cfg_we   (cfg_we),
            .ticlr_we (ticlr_we),
            .wr_mask  (csr_wr_mask),
            .wr_value (csr_wr_value),
            .cfg      (cfg),
            .cnt      (cnt),
            .pending  (pending)
        );

        // TICLR reads as zero, so it contributes no term here.
        assign chan_rd[i]   = ({32{rd_cfg}} & 32'(cfg)) | ({32{rd_val}} & 32'(cnt));
        assign timer_int[i] = pending;
    end

    always_comb begin
        logic [31:0] acc;
        acc = {32{csr_rd_num == CSR_BASE + TID_OFS}} & tid;
        for (int i = 0; i < NUM_TIMERS; i++) begin
            acc = acc | chan_rd[i];
        end
        csr_rd_value = {32{csr_re}} & acc;
    end

    assign has_timer_int = |timer_int;

endmodule

// File: tb/tb_csr_timer_bank.sv
// tb_csr_timer_bank
//   Directed bench for csr_timer_bank: one-shot and periodic countdown,
//   set/clear collision, halt, masked TCFG writes, TID writes and async reset.
module tb_csr_timer_bank;

    localparam logic [13:0] TID    = 14'h40;
    localparam logic [13:0] TCFG0  = 14'h41;
    localparam logic [13:0] TVAL0  = 14'h42;
    localparam logic [13:0] UNMAP  = 14'h43;
    localparam logic [13:0] TICLR0 = 14'h44;
    localparam logic [13:0] TCFG1  = 14'h49;
    localparam logic [13:0] TVAL1  = 14'h4A;
    localparam logic [13:0] TICLR1 = 14'h4C;
    localparam logic [31:0] ID     = 32'hA5A5_0000;
    localparam logic [31:0] ONES   = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        halt;
    logic        csr_we;
    logic [13:0] csr_wr_num;
    logic [31:0] csr_wr_mask;
    logic [31:0] csr_wr_value;
    logic        csr_re;
    logic [13:0] csr_rd_num;
    logic [31:0] csr_rd_value;
    logic [63:0] stable_cnt;
    logic [1:0]  timer_int;
    logic        has_timer_int;

    logic [63:0] exp_stable;
    int          n_cmp = 0;
    int          n_err = 0;

    csr_timer_bank #(
        .NUM_TIMERS (2),
        .CNT_W      (32),
        .STABLE_W   (64),
        .CSR_BASE   (14'h40),
        .CORE_ID    (ID)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .halt          (halt),
        .csr_we        (csr_we),
        .csr_wr_num    (csr_wr_num),
        .csr_wr_mask   (csr_wr_mask),
        .csr_wr_value  (csr_wr_value),
        .csr_re        (csr_re),
        .csr_rd_num    (csr_rd_num),
        .csr_rd_value  (csr_rd_value),
        .stable_cnt    (stable_cnt),
        .timer_int     (timer_int),
        .has_timer_int (has_timer_int)
    );

    always #5 clk = ~clk;

    // Reference for the free-running counter.
    always @(posedge clk or posedge reset) begin
        if (reset) exp_stable <= 64'd0;
        else       exp_stable <= exp_stable + 64'd1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Write is presented for exactly one rising edge; returns at the next negedge.
    task automatic wr(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
        csr_we       = 1'b1;
        csr_wr_num   = num;
        csr_wr_mask  = mask;
        csr_wr_value = val;
        @(negedge clk);
        csr_we       = 1'b0;
    endtask

    task automatic chk_reg(input string tag, input logic [13:0] num, input logic [31:0] exp);
        csr_re     = 1'b1;
        csr_rd_num = num;
        #1;
        check_eq(tag, {32'd0, csr_rd_value}, {32'd0, exp});
        csr_re     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; halt = 1'b0; csr_we = 1'b0; csr_wr_num = '0;
        csr_wr_mask = '0; csr_wr_value = '0; csr_re = 1'b0; csr_rd_num = '0;
        #12;
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk_reg("rst_tval0", TVAL0, ONES);
        chk_reg("rst_tval1", TVAL1, ONES);
        chk_reg("rst_tcfg0", TCFG0, 32'h0);
        chk_reg("rst_tid", TID, ID);
        check_eq("rst_int", {62'd0, timer_int}, 64'd0);
        check_eq("rst_stable", stable_cnt, 64'd0);
        step(1);
        check_eq("stable_1", stable_cnt, 64'd1);

        // One-shot: initval 5 -> 20 down to 0, interrupt a cycle after zero
        wr(TCFG0, ONES, 32'h15);
        chk_reg("os_tval_load", TVAL0, 32'd20);
        chk_reg("os_tcfg", TCFG0, 32'h15);
        for (int k = 19; k >= 0; k--) begin
            step(1);
            chk_reg("os_tval", TVAL0, 32'(k));
        end
        check_eq("os_int_at_zero", {63'd0, timer_int[0]}, 64'd0);
        step(1);
        chk_reg("os_tval_wrap", TVAL0, ONES);
        check_eq("os_int", {63'd0, timer_int[0]}, 64'd1);
        check_eq("os_has_int", {63'd0, has_timer_int}, 64'd1);
        step(2);
        chk_reg("os_tval_stop", TVAL0, ONES);
        chk_reg("ticlr_reads0", TICLR0, 32'h0);
        wr(TICLR0, 32'h1, 32'h1);
        check_eq("os_clr", {63'd0, timer_int[0]}, 64'd0);
        check_eq("os_has_clr", {63'd0, has_timer_int}, 64'd0);

        // Periodic: initval 2 -> 8..0 then reload 8
        wr(TCFG1, ONES, 32'h0B);
        chk_reg("per_load", TVAL1, 32'd8);
        for (int k = 7; k >= 0; k--) begin
            step(1);
            chk_reg("per_tval", TVAL1, 32'(k));
        end
        check_eq("per_int_at_zero", {63'd0, timer_int[1]}, 64'd0);
        step(1);
        chk_reg("per_reload", TVAL1, 32'd8);
        check_eq("per_int", {63'd0, timer_int[1]}, 64'd1);
        wr(TICLR1, 32'h1, 32'h1);
        check_eq("per_clr", {63'd0, timer_int[1]}, 64'd0);
        chk_reg("per_tval7", TVAL1, 32'd7);

        // Set and clear collide in the zero cycle: set wins
        step(7);
        chk_reg("col_zero", TVAL1, 32'd0);
        wr(TICLR1, 32'h1, 32'h1);
        check_eq("col_int", {63'd0, timer_int[1]}, 64'd1);
        chk_reg("col_reload", TVAL1, 32'd8);
        wr(TICLR1, 32'h1, 32'h1);
        check_eq("col_clr", {63'd0, timer_int[1]}, 64'd0);
        wr(TCFG1, 32'h1, 32'h0);
        chk_reg("dis_hold", TVAL1, 32'd7);
        chk_reg("dis_tcfg", TCFG1, 32'h0A);
        step(3);
        chk_reg("dis_hold3", TVAL1, 32'd7);

        // Halt for 10 cycles at TVAL=13, then halt while sitting at zero
        wr(TCFG0, ONES, 32'h15);
        step(7);
        chk_reg("halt_pre", TVAL0, 32'd13);
        check_eq("halt_stable_pre", stable_cnt, exp_stable);
        halt = 1'b1;
        step(10);
        chk_reg("halt_hold", TVAL0, 32'd13);
        check_eq("halt_stable", stable_cnt, exp_stable);
        halt = 1'b0;
        step(13);
        chk_reg("halt_zero", TVAL0, 32'd0);
        halt = 1'b1;
        step(3);
        chk_reg("halt_zero_hold", TVAL0, 32'd0);
        check_eq("halt_no_int", {63'd0, timer_int[0]}, 64'd0);
        halt = 1'b0;
        step(1);
        chk_reg("halt_wrap", TVAL0, ONES);
        check_eq("halt_int_after", {63'd0, timer_int[0]}, 64'd1);
        wr(TICLR0, 32'h1, 32'h1);

        // Masked TCFG write clears en only; counter freezes
        wr(TCFG0, ONES, 32'h15);
        step(2);
        chk_reg("mask_pre", TVAL0, 32'd18);
        wr(TCFG0, 32'h1, 32'h0);
        chk_reg("mask_tcfg", TCFG0, 32'h14);
        chk_reg("mask_freeze", TVAL0, 32'd18);
        step(3);
        chk_reg("mask_freeze3", TVAL0, 32'd18);
        wr(TCFG0, 32'h1, 32'h1);
        chk_reg("mask_reen", TVAL0, 32'd20);
        wr(TVAL0, ONES, 32'h0);
        chk_reg("tval_ro", TVAL0, 32'd19);
        wr(UNMAP, ONES, 32'h77);
        chk_reg("unmap_rd", UNMAP, 32'h0);
        chk_reg("unmap_tcfg", TCFG0, 32'h15);
        wr(TID, 32'h0000_FFFF, 32'h1234);
        chk_reg("tid_wr", TID, 32'hA5A5_1234);
        csr_re = 1'b0; csr_rd_num = TID; #1;
        check_eq("re_low", {32'd0, csr_rd_value}, 64'd0);

        // Async reset mid-count with an interrupt pending
        wr(TCFG1, ONES, 32'h01);
        step(1);
        check_eq("ar_pre_int", {63'd0, timer_int[1]}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("ar_int", {62'd0, timer_int}, 64'd0);
        check_eq("ar_stable", stable_cnt, 64'd0);
        chk_reg("ar_tval0", TVAL0, ONES);
        chk_reg("ar_tval1", TVAL1, ONES);
        chk_reg("ar_tid", TID, ID);
        chk_reg("ar_unmap", UNMAP, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        step(1);
        check_eq("ar_stable_run", stable_cnt, exp_stable);
        chk_reg("ar_tval0_idle", TVAL0, ONES);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
